// File: rtl/burst_memory_pkg.sv
// Shared encodings for the burst memory: access sizes, FSM states and the
// access-size to burst-length mapping.
package burst_memory_pkg;

    typedef logic [1:0] access_size_t;

    localparam access_size_t AS_1W  = 2'b00;
    localparam access_size_t AS_4W  = 2'b01;
    localparam access_size_t AS_8W  = 2'b10;
    localparam access_size_t AS_16W = 2'b11;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] burst_len(input access_size_t as);
        logic [CNT_W-1:0] len;
        case (as)
            AS_1W:   len = 5'd1;
            AS_4W:   len = 5'd4;
            AS_8W:   len = 5'd8;
            default: len = 5'd16;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/burst_memory_if.sv
// Request/response bundle between a requester (fetch, memory stage, loader)
// and the burst memory.
interface burst_memory_if
    import burst_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BPW = DATA_WIDTH / 8;

    // Handshake: a request is accepted at a rising edge where enable=1 and
    // busy=0; enable seen while busy=1 is dropped, never queued. Write data and
    // byte_en are taken on every beat edge, read beats are marked by data_valid.
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [BPW-1:0]        byte_en;
    access_size_t          access_size;
    logic                  rw;
    logic                  enable;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;

    modport master (
        output address, data_in, byte_en, access_size, rw, enable,
        input  busy, data_out, data_valid
    );

    modport slave (
        input  address, data_in, byte_en, access_size, rw, enable,
        output busy, data_out, data_valid
    );

endinterface

// File: rtl/burst_memory_mem_byte_array.sv
// Byte-wide storage with one big-endian word port: per-byte write enables,
// registered read, and byte indices that wrap at the top of the array.
module burst_memory_mem_byte_array
    import burst_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 1048576,
    localparam int BPW        = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(DEPTH_BYTES)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BPW-1:0]        i_be,
    input  logic                  i_we,
    input  logic                  i_re,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [7:0]            r_mem [DEPTH_BYTES];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rword;

    // Byte at offset b from i_idx lives in the b-th most significant lane.
    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int b = 0; b < BPW; b++) begin
                if (i_be[BPW-1-b]) begin
                    r_mem[i_idx + IDX_W'(b)] <= i_wdata[(BPW-1-b)*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rword = '0;
        for (int b = 0; b < BPW; b++) begin
            w_rword[(BPW-1-b)*8 +: 8] = r_mem[i_idx + IDX_W'(b)];
        end
    end

    // Read register holds its value between read beats; the array itself is never cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_rword;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/burst_memory.sv
// Unified big-endian burst memory: accepts 1/4/8/16-word read or write bursts,
// walks the beat addresses and drives busy/data_valid around a byte array.
module burst_memory
    import burst_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_BYTES = 1048576
) (
    input  logic           clock,
    input  logic           reset_n,
    burst_memory_if.slave  bus,
    output state_t         o_dbg_state
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BPW);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPW - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_MASK   = ADDR_WIDTH'(DEPTH_BYTES - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_next_cnt;
    logic [CNT_W-1:0]      w_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] w_start;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [IDX_W-1:0]      w_beat_idx;
    logic                  w_accept;
    logic                  w_we;
    logic                  w_re;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_accept = bus.enable && (r_state == IDLE);
    assign w_len    = burst_len(bus.access_size);
    assign w_start  = bus.address & ALIGN_MASK;

    // Beat 0 is served at the accept edge itself; r_cnt then holds the beats
    // still to come, so the edge that sees r_cnt==1 performs the last beat.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_addr  = r_addr;
        w_beat_addr  = r_addr;
        w_we         = 1'b0;
        w_re         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_beat_addr = w_start;
                    w_we        = bus.rw;
                    w_re        = !bus.rw;
                    w_next_cnt  = w_len - CNT_W'(1);
                    w_next_addr = w_start + STEP;
                    if (w_len != CNT_W'(1)) begin
                        w_next_state = bus.rw ? WR_BURST : RD_BURST;
                    end
                end
            end
            RD_BURST, WR_BURST: begin
                w_we        = (r_state == WR_BURST);
                w_re        = (r_state == RD_BURST);
                w_next_cnt  = r_cnt - CNT_W'(1);
                w_next_addr = r_addr + STEP;
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_addr  <= w_next_addr;
            r_valid <= w_re;
        end
    end

    // Only the low bits select a byte, so bursts wrap over the top of storage.
    assign w_beat_idx = IDX_W'(w_beat_addr & IDX_MASK);

    burst_memory_mem_byte_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .i_idx   (w_beat_idx),
        .i_wdata (bus.data_in),
        .i_be    (bus.byte_en),
        .i_we    (w_we),
        .i_re    (w_re),
        .o_rdata (w_rdata)
    );

    assign bus.busy       = (r_state != IDLE);
    assign bus.data_out   = w_rdata;
    assign bus.data_valid = r_valid;
    assign o_dbg_state    = r_state;

endmodule
